// File: rtl/rtl_settings_pkg.sv
// ---------------------------------------------------------------------------
// rtl_settings_pkg
// Shared settings for the write/compare datapath: the bus and address widths,
// the address type, the compare descriptor, data-mode and compare-FSM enums,
// the LFSR tap mask and the LFSR step function.
// ---------------------------------------------------------------------------
package rtl_settings_pkg;

   localparam int unsigned ADDR_W      = 32;              // byte address width
   localparam int unsigned AMM_DATA_W  = 128;
   localparam int unsigned DATA_B_W    = AMM_DATA_W / 8;  // bytes per bus word
   localparam int unsigned ADDR_B_W    = $clog2(DATA_B_W);
   localparam int unsigned AMM_ADDR_W  = 32;
   localparam int unsigned AMM_BURST_W = 8;
   localparam int unsigned WADDR_W     = ADDR_W - ADDR_B_W; // word address width
   localparam string       ADDR_TYPE   = "BYTE";            // "BYTE" or "WORD"

   // Feedback taps r[6], r[1], r[0].
   localparam logic [7:0]  LFSR_TAPS   = 8'h43;

   typedef enum logic {FIX_DATA, RND_DATA} data_mode_t;

   typedef enum logic [1:0] {IDLE, RD_REQ, RD_DATA} cmp_state_t;

   typedef struct packed {
      logic [WADDR_W-1:0]     start_addr;
      logic [ADDR_B_W-1:0]    start_off;
      logic [ADDR_B_W-1:0]    end_off;
      logic [AMM_BURST_W-2:0] words_count;  // beats - 1
      data_mode_t             data_mode;
      logic [7:0]             data_ptrn;    // fixed byte or LFSR seed
   } cmp_struct_t;

   function automatic logic [7:0] lfsr_next(input logic [7:0] r);
      return {r[6:0], ^(r & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/rnd_data_gen.sv
// ---------------------------------------------------------------------------
// rnd_data_gen
// 8-bit LFSR pattern source shared by the write and compare paths.
//   clk_i, rst_n_i : clock, asynchronous active-low reset
//   load_i, seed_i : load the seed (takes priority over advance)
//   adv_i          : step the LFSR once
//   data_o         : current pattern byte
// ---------------------------------------------------------------------------
module rnd_data_gen
   import rtl_settings_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       load_i,
   input  logic [7:0] seed_i,
   input  logic       adv_i,
   output logic [7:0] data_o
);

   logic [7:0] r_lfsr;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_lfsr <= '0;
      end else if (load_i) begin
         r_lfsr <= seed_i;
      end else if (adv_i) begin
         r_lfsr <= lfsr_next(r_lfsr);
      end
   end

   assign data_o = r_lfsr;

endmodule

// File: rtl/compare_block.sv
// ---------------------------------------------------------------------------
// compare_block
// Reads back a written region over Avalon-MM and checks every enabled byte
// against a fixed or LFSR pattern; reports the first bad byte per burst and
// read timeouts.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   cmp_en_i, cmp_struct_i  : compare request and its descriptor
//   cmp_ready_o             : high while idle
//   waitrequest_i, readdatavalid_i, readdata_i,
//   address_o, read_o, burstcount_o : Avalon-MM burst read master
//   cmp_error_o, err_addr_o, err_data_o, err_exp_o : first-mismatch report
//   timeout_o               : read-timeout pulse
// Optional: define CMP_ERR_CNT_EN to add err_cnt_clr_i / err_cnt_o, a
// saturating count of every failing beat.
// ---------------------------------------------------------------------------
module compare_block
   import rtl_settings_pkg::*;
#(
   parameter int unsigned RD_TIMEOUT = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   cmp_en_i,
   input  cmp_struct_t            cmp_struct_i,
   output logic                   cmp_ready_o,
   input  logic                   waitrequest_i,
   input  logic                   readdatavalid_i,
   input  logic [AMM_DATA_W-1:0]  readdata_i,
   output logic [AMM_ADDR_W-1:0]  address_o,
   output logic                   read_o,
   output logic [AMM_BURST_W-1:0] burstcount_o,
   output logic                   cmp_error_o,
   output logic [ADDR_W-1:0]      err_addr_o,
   output logic [7:0]             err_data_o,
   output logic [7:0]             err_exp_o,
   output logic                   timeout_o
`ifdef CMP_ERR_CNT_EN
   ,
   input  logic                   err_cnt_clr_i,
   output logic [31:0]            err_cnt_o
`endif
);

   localparam int unsigned TO_W   = $clog2(RD_TIMEOUT + 1);
   localparam int unsigned BCNT_W = AMM_BURST_W - 1;
   localparam bit          IS_BYTE = (ADDR_TYPE == "BYTE");

   cmp_state_t              r_state, w_state_nxt;
   cmp_struct_t             r_cmp;
   logic [BCNT_W-1:0]       r_beat_cnt, r_beat_idx;
   logic [TO_W-1:0]         r_to_cnt;
   logic                    r_err_seen;
   logic                    r_read, r_cmp_error, r_timeout;
   logic [AMM_ADDR_W-1:0]   r_address;
   logic [AMM_BURST_W-1:0]  r_burstcount;
   logic [ADDR_W-1:0]       r_err_addr;
   logic [7:0]              r_err_data, r_err_exp;

   logic                    w_accept, w_req_done, w_beat, w_to_hit, w_beat_bad;
   logic                    w_first, w_last;
   logic [DATA_B_W-1:0]     w_byte_en, w_byte_bad;
   logic [ADDR_B_W-1:0]     w_bad_idx;
   logic [7:0]              w_exp, w_lfsr;
   logic [WADDR_W-1:0]      w_beat_waddr;

   assign w_accept   = (r_state == IDLE) && cmp_en_i;
   assign w_req_done = (r_state == RD_REQ) && !waitrequest_i;
   assign w_beat     = (r_state == RD_DATA) && readdatavalid_i;
   assign w_to_hit   = (r_state == RD_DATA) && !readdatavalid_i &&
                       (r_to_cnt == TO_W'(RD_TIMEOUT - 1));
   // Word address of the current beat; wraps within the word address space.
   assign w_beat_waddr = r_cmp.start_addr + WADDR_W'(r_beat_idx);

   rnd_data_gen u_rnd_data_gen (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .load_i  (w_accept),
      .seed_i  (cmp_struct_i.data_ptrn),
      .adv_i   (w_beat),
      .data_o  (w_lfsr)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (cmp_en_i) w_state_nxt = RD_REQ;
         RD_REQ:  if (!waitrequest_i) w_state_nxt = RD_DATA;
         RD_DATA: if ((readdatavalid_i && r_beat_cnt == '0) || w_to_hit) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Byte enables and per-byte mismatch for the beat on the bus.
   always_comb begin
      w_exp      = (r_cmp.data_mode == RND_DATA) ? w_lfsr : r_cmp.data_ptrn;
      w_first    = (r_beat_idx == '0);
      w_last     = (r_beat_cnt == '0);
      w_byte_en  = '1;
      w_byte_bad = '0;
      w_bad_idx  = '0;
      for (int i = 0; i < DATA_B_W; i++) begin
         if (IS_BYTE) begin
            if (w_first && (ADDR_B_W'(i) < r_cmp.start_off)) w_byte_en[i] = 1'b0;
            if (w_last && (ADDR_B_W'(i) > r_cmp.end_off)) w_byte_en[i] = 1'b0;
         end
         w_byte_bad[i] = w_byte_en[i] && (readdata_i[8*i +: 8] != w_exp);
      end
      // Scan downward so the lowest failing byte wins.
      for (int i = DATA_B_W - 1; i >= 0; i--) begin
         if (w_byte_bad[i]) w_bad_idx = ADDR_B_W'(i);
      end
      w_beat_bad = w_beat && (|w_byte_bad);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_cmp        <= '0;
         r_beat_cnt   <= '0;
         r_beat_idx   <= '0;
         r_to_cnt     <= '0;
         r_err_seen   <= 1'b0;
         r_read       <= 1'b0;
         r_cmp_error  <= 1'b0;
         r_timeout    <= 1'b0;
         r_address    <= '0;
         r_burstcount <= '0;
         r_err_addr   <= '0;
         r_err_data   <= '0;
         r_err_exp    <= '0;
      end else begin
         r_cmp_error <= 1'b0;
         r_timeout   <= 1'b0;
         if (w_accept) begin
            r_cmp        <= cmp_struct_i;
            r_read       <= 1'b1;
            r_address    <= IS_BYTE ?
                            AMM_ADDR_W'({cmp_struct_i.start_addr, {ADDR_B_W{1'b0}}}) :
                            AMM_ADDR_W'(cmp_struct_i.start_addr);
            r_burstcount <= {1'b0, cmp_struct_i.words_count} + AMM_BURST_W'(1);
            r_err_seen   <= 1'b0;
         end
         if (w_req_done) begin
            r_read     <= 1'b0;
            r_beat_cnt <= r_cmp.words_count;
            r_beat_idx <= '0;
            r_to_cnt   <= '0;
         end
         if (w_beat) begin
            r_beat_cnt <= r_beat_cnt - BCNT_W'(1);
            r_beat_idx <= r_beat_idx + BCNT_W'(1);
            r_to_cnt   <= '0;
            if (w_beat_bad && !r_err_seen) begin
               r_cmp_error <= 1'b1;
               r_err_seen  <= 1'b1;
               r_err_addr  <= {w_beat_waddr, w_bad_idx};
               r_err_data  <= readdata_i[8*w_bad_idx +: 8];
               r_err_exp   <= w_exp;
            end
         end else if (r_state == RD_DATA) begin
            if (w_to_hit) begin
               r_timeout <= 1'b1;
            end else begin
               r_to_cnt <= r_to_cnt + TO_W'(1);
            end
         end
      end
   end

   assign cmp_ready_o  = (r_state == IDLE);
   assign read_o       = r_read;
   assign address_o    = r_address;
   assign burstcount_o = r_burstcount;
   assign cmp_error_o  = r_cmp_error;
   assign err_addr_o   = r_err_addr;
   assign err_data_o   = r_err_data;
   assign err_exp_o    = r_err_exp;
   assign timeout_o    = r_timeout;

`ifdef CMP_ERR_CNT_EN
   logic [31:0] r_err_cnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_err_cnt <= '0;
      end else if (err_cnt_clr_i) begin
         r_err_cnt <= '0;
      end else if (w_beat_bad && (r_err_cnt != '1)) begin
         r_err_cnt <= r_err_cnt + 32'd1;
      end
   end

   assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_compare_block.sv
// ---------------------------------------------------------------------------
// tb_compare_block
// Directed bench for compare_block: stimulus pushes expected error/timeout
// events into a queue, a negedge monitor pops and checks them.
// ---------------------------------------------------------------------------
module tb_compare_block;
   import rtl_settings_pkg::*;

   localparam int unsigned TO = 16;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   cmp_en = 1'b0;
   cmp_struct_t            cs;
   logic                   cmp_ready;
   logic                   waitreq = 1'b0;
   logic                   rdv = 1'b0;
   logic [AMM_DATA_W-1:0]  rdata;
   logic [AMM_ADDR_W-1:0]  address;
   logic                   read;
   logic [AMM_BURST_W-1:0] burstcount;
   logic                   cmp_error;
   logic [ADDR_W-1:0]      err_addr;
   logic [7:0]             err_data, err_exp;
   logic                   timeout;
`ifdef CMP_ERR_CNT_EN
   logic                   err_cnt_clr = 1'b0;
   logic [31:0]            err_cnt;
`endif

   compare_block #(.RD_TIMEOUT(TO)) dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .cmp_en_i        (cmp_en),
      .cmp_struct_i    (cs),
      .cmp_ready_o     (cmp_ready),
      .waitrequest_i   (waitreq),
      .readdatavalid_i (rdv),
      .readdata_i      (rdata),
      .address_o       (address),
      .read_o          (read),
      .burstcount_o    (burstcount),
      .cmp_error_o     (cmp_error),
      .err_addr_o      (err_addr),
      .err_data_o      (err_data),
      .err_exp_o       (err_exp),
      .timeout_o       (timeout)
`ifdef CMP_ERR_CNT_EN
      ,
      .err_cnt_clr_i   (err_cnt_clr),
      .err_cnt_o       (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit              is_to;
      logic [ADDR_W-1:0] addr;
      logic [7:0]      data;
      logic [7:0]      exp;
      int              cyc;
   } ev_t;

   ev_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every error/timeout pulse must match the head of the queue.
   always @(negedge clk) begin
      if (rst_n && (cmp_error || timeout)) begin
         if (sb.size() == 0) begin
            chk("unexpected_event", {62'd0, cmp_error, timeout}, 64'd0);
         end else begin
            ev_t e;
            e = sb.pop_front();
            if (e.is_to) begin
               chk("timeout_pulse", timeout, 1);
               chk("timeout_cycle", cyc, e.cyc);
               chk("timeout_no_err", cmp_error, 0);
            end else begin
               chk("err_pulse", cmp_error, 1);
               chk("err_addr", err_addr, e.addr);
               chk("err_data", err_data, e.data);
               chk("err_exp", err_exp, e.exp);
            end
         end
      end
   end

   function automatic logic [AMM_DATA_W-1:0] fill(input logic [7:0] b);
      return {DATA_B_W{b}};
   endfunction

   function automatic logic [AMM_DATA_W-1:0] setb(input logic [AMM_DATA_W-1:0] w,
                                                  input int i, input logic [7:0] b);
      w[8*i +: 8] = b;
      return w;
   endfunction

   function automatic cmp_struct_t mk(input logic [WADDR_W-1:0] a, input int so, input int eo,
                                      input int wc, input data_mode_t m, input logic [7:0] p);
      cmp_struct_t s;
      s.start_addr  = a;
      s.start_off   = ADDR_B_W'(so);
      s.end_off     = ADDR_B_W'(eo);
      s.words_count = (AMM_BURST_W-1)'(wc);
      s.data_mode   = m;
      s.data_ptrn   = p;
      return s;
   endfunction

   task automatic exp_err(input logic [ADDR_W-1:0] a, input logic [7:0] d, input logic [7:0] e);
      ev_t ev;
      ev.is_to = 1'b0; ev.addr = a; ev.data = d; ev.exp = e; ev.cyc = 0;
      sb.push_back(ev);
   endtask

   // All tasks start and end 1 time unit after a rising edge.
   task automatic issue(input cmp_struct_t s);
      int w = 0;
      while (!cmp_ready && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      chk("ready_before_issue", cmp_ready, 1);
      cmp_en = 1'b1;
      cs = s;
      @(posedge clk); #1;
      cmp_en = 1'b0;
      chk("read_asserted", read, 1);
      chk("ready_low_busy", cmp_ready, 0);
   endtask

   task automatic grant();
      @(posedge clk); #1;
      chk("read_released", read, 0);
   endtask

   task automatic beat(input logic [AMM_DATA_W-1:0] d);
      rdv = 1'b1;
      rdata = d;
      @(posedge clk); #1;
      rdv = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   initial begin
      logic [AMM_DATA_W-1:0] d;
      int w;
      cs = '0;
      rdata = '0;
      repeat (3) @(posedge clk);
      #1;
      // Reset state.
      chk("rst_read", read, 0);
      chk("rst_address", address, 0);
      chk("rst_burstcount", burstcount, 0);
      chk("rst_cmp_error", cmp_error, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_err_addr", err_addr, 0);
      chk("rst_err_data", err_data, 0);
      chk("rst_err_exp", err_exp, 0);
      chk("rst_ready", cmp_ready, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // FIX 0xA5, 4 beats, all good.
      issue(mk(28'h10, 0, 15, 3, FIX_DATA, 8'hA5));
      chk("t1_address", address, 32'h100);
      chk("t1_burstcount", burstcount, 4);
      grant();
      for (int i = 0; i < 3; i++) beat(fill(8'hA5));
      chk("t1_ready_mid", cmp_ready, 0);
      beat(fill(8'hA5));
      chk("t1_ready_end", cmp_ready, 1);

      // Single beat, bytes 3..5 enabled; byte 4 is the first failure.
      issue(mk(28'h20, 3, 5, 0, FIX_DATA, 8'h5A));
      grant();
      d = setb(fill(8'h5A), 0, 8'h00);
      d = setb(d, 2, 8'h11);
      d = setb(d, 4, 8'h00);
      d = setb(d, 5, 8'h00);
      d = setb(d, 6, 8'h77);
      exp_err(32'h204, 8'h00, 8'h5A);
      beat(d);
      chk("t2_ready_end", cmp_ready, 1);

      // RND seed 0xFF: taps r6^r1^r0 keep 0xFF fixed.
      issue(mk(28'h30, 0, 15, 2, RND_DATA, 8'hFF));
      grant();
      beat(fill(8'hFF));
      exp_err(32'h310, 8'h00, 8'hFF);
      beat(setb(fill(8'hFF), 0, 8'h00));
      beat(setb(fill(8'hFF), 7, 8'h00));

      // RND seed 0x01: 01, 03, 06, 0D.
      issue(mk(28'h40, 0, 15, 3, RND_DATA, 8'h01));
      grant();
      beat(fill(8'h01));
      beat(fill(8'h03));
      beat(fill(8'h06));
      exp_err(32'h435, 8'h00, 8'h0D);
      beat(setb(fill(8'h0D), 5, 8'h00));

      // Word-address wrap on the second beat, end_off = 1.
      issue(mk(28'hFFF_FFFF, 0, 1, 1, FIX_DATA, 8'h3C));
      chk("t3c_address", address, 32'hFFFF_FFF0);
      chk("t3c_burstcount", burstcount, 2);
      grant();
      beat(fill(8'h3C));
      d = setb(fill(8'h3C), 1, 8'h00);
      d = setb(d, 2, 8'h00);
      exp_err(32'h0000_0001, 8'h00, 8'h3C);
      beat(d);

      // waitrequest held for 5 cycles; masked corruptions only.
      waitreq = 1'b1;
      issue(mk(28'h50, 2, 9, 1, FIX_DATA, 8'hC3));
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("t4_read_held", read, 1);
         chk("t4_address_held", address, 32'h500);
         chk("t4_burst_held", burstcount, 2);
      end
      waitreq = 1'b0;
      grant();
      d = setb(fill(8'hC3), 0, 8'h00);
      beat(setb(d, 1, 8'h00));
      beat(setb(fill(8'hC3), 10, 8'h00));
      chk("t4_ready_end", cmp_ready, 1);

      // Timeout: no beats at all, then a stray late beat.
      issue(mk(28'h60, 0, 15, 1, FIX_DATA, 8'hAA));
      begin
         ev_t ev;
         ev.is_to = 1'b1; ev.addr = '0; ev.data = '0; ev.exp = '0;
         ev.cyc = cyc + TO + 1;
         sb.push_back(ev);
      end
      w = 0;
      while (!cmp_ready && w < 40) begin
         @(posedge clk); #1;
         w++;
      end
      chk("t5_ready_after_timeout", cmp_ready, 1);
      beat(fill(8'h00));
      repeat (2) @(posedge clk);
      #1;

      // Reset in the middle of RD_DATA.
      issue(mk(28'h70, 0, 15, 2, FIX_DATA, 8'h11));
      grant();
      beat(fill(8'h11));
      rst_n = 1'b0;
      #1;
      chk("t6_rst_read", read, 0);
      chk("t6_rst_address", address, 0);
      chk("t6_rst_burstcount", burstcount, 0);
      chk("t6_rst_err_addr", err_addr, 0);
      chk("t6_rst_err_exp", err_exp, 0);
      chk("t6_rst_ready", cmp_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      beat(fill(8'h00));
      issue(mk(28'h80, 0, 15, 3, FIX_DATA, 8'hEE));
      chk("t6_address", address, 32'h800);
      grant();
      exp_err(32'h803, 8'h00, 8'hEE);
      beat(setb(fill(8'hEE), 3, 8'h00));
      beat(fill(8'hEE));
      beat(setb(fill(8'hEE), 0, 8'h01));
      beat(setb(fill(8'hEE), 15, 8'h02));
      chk("t6_ready_end", cmp_ready, 1);
`ifdef CMP_ERR_CNT_EN
      chk("t6_err_cnt", err_cnt, 3);
      err_cnt_clr = 1'b1;
      @(posedge clk); #1;
      err_cnt_clr = 1'b0;
      chk("t6_err_cnt_clr", err_cnt, 0);
`endif

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
